// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source selects, load funct3 codes, FSM states.
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_MEM
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shift raw word down by the byte offset, then
// sign- or zero-extend according to funct3. Used only with WB_LOAD_EXT_EN.
module load_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata,
  input  logic [2:0]                   funct3,
  input  logic [$clog2(XLEN/8)-1:0]    byte_off,
  output logic [XLEN-1:0]              data_c
);
  import wb_pkg::*;

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {byte_off, 3'b000};

  always_comb begin
    data_c = shifted;
    case (funct3)
      F3_LB:   data_c = XLEN'($signed(shifted[7:0]));
      F3_LH:   data_c = XLEN'($signed(shifted[15:0]));
      F3_LW:   data_c = XLEN'($signed(shifted[31:0]));
      F3_LBU:  data_c = XLEN'(shifted[7:0]);
      F3_LHU:  data_c = XLEN'(shifted[15:0]);
      F3_LWU:  data_c = XLEN'(shifted[31:0]);
      default: data_c = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage with load-wait FSM. Sub-word load alignment and
// extension is present only when WB_LOAD_EXT_EN is defined.
module wb_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_reg_write,
  input  logic [RA_W-1:0]             i_rd_addr,
  input  logic [1:0]                  i_wb_sel,
  input  logic [XLEN-1:0]             i_aluresult,
  input  logic [XLEN-1:0]             i_pc_plus4,
  input  logic [2:0]                  i_load_funct3,
  input  logic [$clog2(XLEN/8)-1:0]   i_byte_off,
  input  logic                        i_mem_rvalid,
  input  logic [XLEN-1:0]             i_mem_rdata,
  output logic                        o_rf_we,
  output logic [RA_W-1:0]             o_rf_waddr,
  output logic [XLEN-1:0]             o_rf_wdata
);
  import wb_pkg::*;

  localparam int unsigned OFF_W = $clog2(XLEN/8);

  wb_state_e       state_q, state_d;
  logic            ready_q;
  logic            accept;
  logic            capture;
  logic [RA_W-1:0] hold_rd_q;
  logic            hold_we_q;
  logic [XLEN-1:0] load_data;

  logic            wr_fire;
  logic            wr_en;
  logic [RA_W-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;

  assign accept  = i_valid && ready_q;
  assign o_ready = ready_q;

`ifdef WB_LOAD_EXT_EN
  logic [2:0]       hold_f3_q;
  logic [OFF_W-1:0] hold_off_q;
  logic [2:0]       f3_sel;
  logic [OFF_W-1:0] off_sel;

  // A zero-wait load aligns with live fields; a waiting load uses the held copy.
  assign f3_sel  = (state_q == ST_IDLE) ? i_load_funct3 : hold_f3_q;
  assign off_sel = (state_q == ST_IDLE) ? i_byte_off    : hold_off_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_f3_q  <= 3'b000;
      hold_off_q <= '0;
    end else if (capture) begin
      hold_f3_q  <= i_load_funct3;
      hold_off_q <= i_byte_off;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata    (i_mem_rdata),
    .funct3   (f3_sel),
    .byte_off (off_sel),
    .data_c   (load_data)
  );
`else
  logic unused_cfg;

  assign load_data  = i_mem_rdata;
  assign unused_cfg = ^{i_load_funct3, i_byte_off, OFF_W[0]};
`endif

  // Holding register for the accepted instruction's destination.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_rd_q <= '0;
      hold_we_q <= 1'b0;
    end else if (capture) begin
      hold_rd_q <= i_rd_addr;
      hold_we_q <= i_reg_write && (i_rd_addr != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    wr_fire = 1'b0;
    wr_en   = 1'b0;
    wr_addr = hold_rd_q;
    wr_data = i_aluresult;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          capture = 1'b1;
          wr_en   = i_reg_write && (i_rd_addr != '0);
          wr_addr = i_rd_addr;
          if (i_wb_sel == WB_MEM) begin
            wr_data = load_data;
            if (i_mem_rvalid) begin
              wr_fire = 1'b1;
            end else begin
              state_d = ST_WAIT_MEM;
            end
          end else begin
            wr_fire = 1'b1;
            wr_data = (i_wb_sel == WB_PC4) ? i_pc_plus4 : i_aluresult;
          end
        end
      end
      ST_WAIT_MEM: begin
        wr_en   = hold_we_q;
        wr_data = load_data;
        if (i_mem_rvalid) begin
          wr_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write port registers; address/data only move on an actual write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_we <= wr_fire && wr_en;
      if (wr_fire && wr_en) begin
        o_rf_waddr <= wr_addr;
        o_rf_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (XLEN=32); expected load values
// follow WB_LOAD_EXT_EN.
module tb_wb_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic            reg_write;
  logic [RA_W-1:0] rd_addr;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] aluresult;
  logic [XLEN-1:0] pc_plus4;
  logic [2:0]      load_funct3;
  logic [1:0]      byte_off;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_reg_write   (reg_write),
    .i_rd_addr     (rd_addr),
    .i_wb_sel      (wb_sel),
    .i_aluresult   (aluresult),
    .i_pc_plus4    (pc_plus4),
    .i_load_funct3 (load_funct3),
    .i_byte_off    (byte_off),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata),
    .o_rf_we       (rf_we),
    .o_rf_waddr    (rf_waddr),
    .o_rf_wdata    (rf_wdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    valid       = 1'b0;
    reg_write   = 1'b0;
    rd_addr     = '0;
    wb_sel      = 2'b00;
    aluresult   = '0;
    pc_plus4    = '0;
    load_funct3 = 3'b000;
    byte_off    = 2'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [RA_W-1:0] rd, input logic wr,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc4);
    idle_in();
    valid     = 1'b1;
    reg_write = wr;
    rd_addr   = rd;
    wb_sel    = sel;
    aluresult = alu;
    pc_plus4  = pc4;
  endtask

  task automatic issue_load(input logic [RA_W-1:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic rv, input logic [XLEN-1:0] data);
    issue(2'b01, rd, 1'b1, 32'hBAD0_0001, 32'hBAD0_0002);
    load_funct3 = f3;
    byte_off    = off;
    mem_rvalid  = rv;
    mem_rdata   = data;
  endtask

  task automatic check_wr(input string tag, input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
    check({tag, "_we"}, 64'(rf_we), 64'd1);
    check({tag, "_waddr"}, 64'(rf_waddr), 64'(a));
    check({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
  endtask

  logic [XLEN-1:0] exp_lb, exp_lbu, exp_lh;

  initial begin
`ifdef WB_LOAD_EXT_EN
    exp_lb  = 32'hFFFF_FF80;
    exp_lbu = 32'h0000_0080;
    exp_lh  = 32'hFFFF_8001;
`else
    exp_lb  = 32'h0080_0000;
    exp_lbu = 32'h0080_0000;
    exp_lh  = 32'h8001_0000;
`endif
    idle_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);

    // ALU path
    issue(2'b00, 5'd5, 1'b1, 32'h1234_5678, 32'h0);
    @(negedge clk);
    check_wr("alu", 5'd5, 32'h1234_5678);
    idle_in();
    @(negedge clk);
    check("alu_we_drop", 64'(rf_we), 64'd0);
    check("alu_hold_wdata", 64'(rf_wdata), 64'h1234_5678);

    // Sub-word loads with zero-wait data
    issue_load(5'd6, 3'b000, 2'd2, 1'b1, 32'h0080_0000);
    @(negedge clk);
    check_wr("lb", 5'd6, exp_lb);
    check("lb_ready", 64'(ready), 64'd1);
    issue_load(5'd7, 3'b100, 2'd2, 1'b1, 32'h0080_0000);
    @(negedge clk);
    check_wr("lbu", 5'd7, exp_lbu);
    issue_load(5'd8, 3'b001, 2'd2, 1'b1, 32'h8001_0000);
    @(negedge clk);
    check_wr("lh", 5'd8, exp_lh);

    // Load waiting three cycles; a valid ALU op offered meanwhile must not be taken
    issue_load(5'd9, 3'b010, 2'd0, 1'b0, 32'h1111_1111);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("wait_ready_%0d", i), 64'(ready), 64'd0);
      check($sformatf("wait_we_%0d", i), 64'(rf_we), 64'd0);
      issue(2'b00, 5'd3, 1'b1, 32'hCAFE_0000, 32'h0);
      mem_rdata = 32'h2222_2222;
    end
    @(negedge clk);
    check("wait_ready_4", 64'(ready), 64'd0);
    idle_in();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_wr("lw_wait", 5'd9, 32'hDEAD_BEEF);
    check("lw_ready_back", 64'(ready), 64'd1);
    idle_in();
    @(negedge clk);
    check("lw_we_drop", 64'(rf_we), 64'd0);

    // x0 and reg_write=0 suppression
    issue(2'b10, 5'd0, 1'b1, 32'h0, 32'h0000_0100);
    @(negedge clk);
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_ready", 64'(ready), 64'd1);
    check("x0_wdata_held", 64'(rf_wdata), 64'hDEAD_BEEF);
    issue(2'b00, 5'd4, 1'b0, 32'h4444_4444, 32'h0);
    @(negedge clk);
    check("nowr_we", 64'(rf_we), 64'd0);
    check("nowr_waddr_held", 64'(rf_waddr), 64'd9);

    // Reset while waiting drops the load
    issue_load(5'd10, 3'b010, 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    check("rw_ready_wait", 64'(ready), 64'd0);
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_ready", 64'(ready), 64'd1);
    check("rw_wdata_clr", 64'(rf_wdata), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    @(negedge clk);
    check("rw_we", 64'(rf_we), 64'd0);
    check("rw_ready_after", 64'(ready), 64'd1);
    idle_in();
    @(negedge clk);
    check("rw_we_2", 64'(rf_we), 64'd0);

    // Back-to-back: ALU, PC+4, reserved select (acts as ALU)
    issue(2'b00, 5'd1, 1'b1, 32'hAAAA_0001, 32'h0000_0300);
    @(negedge clk);
    check_wr("b2b_1", 5'd1, 32'hAAAA_0001);
    issue(2'b10, 5'd2, 1'b1, 32'hAAAA_0002, 32'h0000_0200);
    @(negedge clk);
    check_wr("b2b_2", 5'd2, 32'h0000_0200);
    issue(2'b11, 5'd3, 1'b1, 32'hAAAA_0003, 32'h0000_0400);
    @(negedge clk);
    check_wr("b2b_3", 5'd3, 32'hAAAA_0003);
    check("b2b_ready", 64'(ready), 64'd1);
    idle_in();
    @(negedge clk);
    check("b2b_we_drop", 64'(rf_we), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
